// File: rtl/huffman_decoder_if.sv
// Bundles the code-table load, serial bit input and decoded symbol outputs of huffman_decoder.
interface huffman_decoder_if;
  logic       code_valid;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic       bit_valid;
  logic       bit_in;
  logic       sym_valid;
  logic [7:0] sym_data;
  logic       err;
  logic [7:0] sym_cnt;
  logic       ready;

  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
           M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
    input  sym_valid, sym_data, err, sym_cnt, ready
  );

  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
           M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
    output sym_valid, sym_data, err, sym_cnt, ready
  );
endinterface

// File: rtl/huffman_decoder.sv
// Serial prefix-code decoder: six loadable (code, mask) entries, one bit per cycle,
// symbol k reported one cycle after its last bit; sticky error on a 7-bit non-match.
module huffman_decoder (
  input logic              clk,
  input logic              reset,
  huffman_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, ERROR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hc_q     [6];
  logic [7:0]  m_q      [6];
  logic [2:0]  len_tab_q[6];
  logic [5:0]  en_q;
  logic [7:0]  shift_q;
  logic [2:0]  len_q;

  logic [7:0]  hc_in [6];
  logic [7:0]  m_in  [6];
  logic [5:0]  en_in;
  logic [2:0]  len_in[6];
  logic [7:0]  next_bits;
  logic [2:0]  len_next;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        take_bit;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned j = 0; j < 8; j++) c = c + 4'(v[j]);
    return c;
  endfunction

  // A usable mask is 2^n-1 with 1 <= n <= 7; anything else disables the entry.
  always_comb begin
    hc_in = '{bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6};
    m_in  = '{bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6};
    en_in = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      logic [3:0] pc;
      en_in[i]  = (m_in[i] != '0) && !m_in[i][7] && ((m_in[i] & (m_in[i] + 8'd1)) == '0);
      pc        = popcount8(m_in[i]);
      len_in[i] = en_in[i] ? pc[2:0] : 3'd0;
    end
  end

  // Scan from entry 1 upward so the lowest matching index wins.
  always_comb begin
    next_bits = {shift_q[6:0], bus.bit_in};
    len_next  = len_q + 3'd1;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!hit && en_q[i] && (len_next == len_tab_q[i]) &&
          ((next_bits & m_q[i]) == (hc_q[i] & m_q[i]))) begin
        hit     = 1'b1;
        hit_idx = 3'(i + 1);
      end
    end
  end

  assign take_bit = (state_q == DECODE) && bus.bit_valid && !bus.code_valid;

  always_comb begin
    state_d = state_q;
    if (bus.code_valid)
      state_d = DECODE;
    else if (take_bit && !hit && (len_next == 3'd7))
      state_d = ERROR;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 6; i++) begin
        hc_q[i]      <= '0;
        m_q[i]       <= '0;
        len_tab_q[i] <= '0;
      end
      en_q          <= '0;
      shift_q       <= '0;
      len_q         <= '0;
      bus.sym_valid <= 1'b0;
      bus.sym_data  <= '0;
      bus.err       <= 1'b0;
      bus.sym_cnt   <= '0;
      bus.ready     <= 1'b0;
    end else begin
      bus.sym_valid <= 1'b0;
      bus.ready     <= (state_d == DECODE);
      bus.err       <= (state_d == ERROR);
      if (bus.code_valid) begin
        hc_q        <= hc_in;
        m_q         <= m_in;
        len_tab_q   <= len_in;
        en_q        <= en_in;
        shift_q     <= '0;
        len_q       <= '0;
        bus.sym_cnt <= '0;
      end else if (take_bit) begin
        if (hit) begin
          bus.sym_valid <= 1'b1;
          bus.sym_data  <= {5'd0, hit_idx};
          shift_q       <= '0;
          len_q         <= '0;
          if (bus.sym_cnt != 8'hFF) bus.sym_cnt <= bus.sym_cnt + 8'd1;
        end else if (len_next == 3'd7) begin
          shift_q <= '0;
          len_q   <= '0;
        end else begin
          shift_q <= next_bits;
          len_q   <= len_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder.
module tb_huffman_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses;
  logic [7:0] tab_hc[6];
  logic [7:0] tab_m [6];

  huffman_decoder_if bus();

  huffman_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t();
    tab_hc = '{8'd0, 8'd2, 8'd6, 8'd14, 8'd30, 8'd31};
    tab_m  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
  endtask

  task automatic drive_table();
    bus.HC1 = tab_hc[0]; bus.HC2 = tab_hc[1]; bus.HC3 = tab_hc[2];
    bus.HC4 = tab_hc[3]; bus.HC5 = tab_hc[4]; bus.HC6 = tab_hc[5];
    bus.M1  = tab_m[0];  bus.M2  = tab_m[1];  bus.M3  = tab_m[2];
    bus.M4  = tab_m[3];  bus.M5  = tab_m[4];  bus.M6  = tab_m[5];
  endtask

  task automatic load();
    drive_table();
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sym_valid"}, bus.sym_valid, 0);
    check({tag, "_sym_data"},  bus.sym_data,  0);
    check({tag, "_err"},       bus.err,       0);
    check({tag, "_sym_cnt"},   bus.sym_cnt,   0);
    check({tag, "_ready"},     bus.ready,     0);
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    set_t();
    drive_table();

    // Reset state, and bits ignored in IDLE
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    send_bit(1'b0);
    check("idle_bit_sv", bus.sym_valid, 0);
    check("idle_ready", bus.ready, 0);

    // Single 1-bit code
    load();
    check("load_ready", bus.ready, 1);
    check("load_err", bus.err, 0);
    send_bit(1'b0);
    check("s1_sv", bus.sym_valid, 1);
    check("s1_data", bus.sym_data, 1);
    check("s1_cnt", bus.sym_cnt, 1);
    tick();
    check("s1_sv_drop", bus.sym_valid, 0);
    check("s1_data_hold", bus.sym_data, 1);

    // Back-to-back codes 10, 110, 11111
    load();
    check("b2b_cnt_clr", bus.sym_cnt, 0);
    send_bit(1'b1); check("b2b_b1", bus.sym_valid, 0);
    send_bit(1'b0); check("b2b_sv2", bus.sym_valid, 1); check("b2b_d2", bus.sym_data, 2);
    send_bit(1'b1); check("b2b_b3", bus.sym_valid, 0);
    send_bit(1'b1); check("b2b_b4", bus.sym_valid, 0);
    send_bit(1'b0); check("b2b_sv3", bus.sym_valid, 1); check("b2b_d3", bus.sym_data, 3);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1); check("b2b_ones", bus.sym_valid, 0);
    end
    send_bit(1'b1); check("b2b_sv6", bus.sym_valid, 1); check("b2b_d6", bus.sym_data, 6);
    check("b2b_cnt", bus.sym_cnt, 3);

    // Undecodable stream with entry 6 disabled
    tab_m[5] = 8'd0;
    load();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      check("err_pre_sv", bus.sym_valid, 0);
      check("err_pre_err", bus.err, 0);
    end
    send_bit(1'b1);
    check("err_sv", bus.sym_valid, 0);
    check("err_set", bus.err, 1);
    check("err_ready", bus.ready, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("err_ign_sv", bus.sym_valid, 0);
    check("err_sticky", bus.err, 1);
    check("err_ign_cnt", bus.sym_cnt, 0);
    set_t();
    load();
    check("err_clr", bus.err, 0);
    check("err_clr_ready", bus.ready, 1);

    // 7-bit code boundary and non-contiguous mask disabled
    tab_hc = '{8'h7F, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
    tab_m  = '{8'h7F, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
    load();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check("len7_pre", bus.sym_valid, 0);
    send_bit(1'b1);
    check("len7_sv", bus.sym_valid, 1);
    check("len7_data", bus.sym_data, 1);
    check("len7_err", bus.err, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("mask5_nomatch", bus.sym_valid, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("mask5_err", bus.err, 1);
    check("mask5_cnt", bus.sym_cnt, 1);

    // code_valid and bit_valid together: bit dropped
    set_t();
    load();
    send_bit(1'b1);
    send_bit(1'b1);
    drive_table();
    bus.code_valid = 1'b1;
    bus.bit_valid  = 1'b1;
    bus.bit_in     = 1'b0;
    tick();
    bus.code_valid = 1'b0;
    bus.bit_valid  = 1'b0;
    check("coll_sv", bus.sym_valid, 0);
    check("coll_cnt", bus.sym_cnt, 0);
    send_bit(1'b0);
    check("coll_sv2", bus.sym_valid, 1);
    check("coll_data", bus.sym_data, 1);

    // Counter saturation over 300 one-bit codes
    load();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      send_bit(1'b0);
      if (bus.sym_valid === 1'b1) pulses++;
      if (i == 254) check("sat_254", bus.sym_cnt, 255);
    end
    check("sat_pulses", pulses, 300);
    check("sat_cnt", bus.sym_cnt, 255);

    // Mid-stream reset
    load();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_outputs("mrst");
    send_bit(1'b0);
    check("mrst_b0", bus.sym_valid, 0);
    send_bit(1'b0);
    check("mrst_b1", bus.sym_valid, 0);
    check("mrst_cnt", bus.sym_cnt, 0);
    load();
    check("mrst_ready", bus.ready, 1);
    send_bit(1'b0);
    check("mrst_sv", bus.sym_valid, 1);
    check("mrst_data", bus.sym_data, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
